// File: rtl/exe_wb_slot_scheduler.sv
// Issue-side scheduler for one execute lane. The lane has three units (simple ALU,
// pipelined complex ALU, iterative divider) that all share one writeback port.
// A reservation table of future writeback slots makes sure that at most one
// result lands per cycle. The writeback source select is read straight from
// the head of that table.
module exe_wb_slot_scheduler #(
  parameter int S_LAT      = 1,
  parameter int C_LAT      = 4,
  parameter int D_LAT      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       recoverFlag_i,
  input  logic       reqS_i,
  input  logic       reqC_i,
  input  logic       reqD_i,
  output logic       grantS_o,
  output logic       grantC_o,
  output logic       grantD_o,
  output logic [1:0] wbSel_o,
  output logic       divBusy_o,
  output logic       starve_o
);

  localparam int MAXL = D_LAT;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_S    = 2'd1;
  localparam logic [1:0] SRC_C    = 2'd2;
  localparam logic [1:0] SRC_D    = 2'd3;

  typedef enum logic {IDLE, BUSY} div_state_t;

  logic [1:0]    r_slot     [0:MAXL];
  logic [1:0]    w_slot_nxt [0:MAXL];
  div_state_t    r_div_state;
  logic [3:0]    r_div_cnt;
  logic [SW-1:0] r_starve_cnt;

  logic w_gate;
  logic w_starve;
  logic w_elig_s;
  logic w_elig_c;
  logic w_elig_d;

  // A unit is eligible when the writeback slot it would land in is still free.
  // slot[L] is the entry that shifts into slot[L-1] on the next edge, so checking
  // it now closes the one-cycle hazard window.
  assign w_gate   = reset && !recoverFlag_i;
  assign w_starve = (r_starve_cnt == SW'(STARVE_MAX));
  assign w_elig_s = reqS_i && (r_slot[S_LAT] == SRC_NONE);
  assign w_elig_c = reqC_i && (r_slot[C_LAT] == SRC_NONE);
  assign w_elig_d = reqD_i && (r_slot[D_LAT] == SRC_NONE) && (r_div_state == IDLE);

  assign wbSel_o   = r_slot[0];
  assign divBusy_o = (r_div_state == BUSY);
  assign starve_o  = w_starve;

  // Grant arbitration: D > C > S normally; under starvation only S may issue.
  always_comb begin
    grantS_o = 1'b0;
    grantC_o = 1'b0;
    grantD_o = 1'b0;
    if (w_gate) begin
      if (w_starve)      grantS_o = w_elig_s;
      else if (w_elig_d) grantD_o = 1'b1;
      else if (w_elig_c) grantC_o = 1'b1;
      else               grantS_o = w_elig_s;
    end
  end

  // Next reservation table: shift toward the head, then claim the granted slot.
  always_comb begin
    for (int k = 0; k < MAXL; k++) w_slot_nxt[k] = r_slot[k+1];
    w_slot_nxt[MAXL] = SRC_NONE;
    if (grantS_o) w_slot_nxt[S_LAT-1] = SRC_S;
    if (grantC_o) w_slot_nxt[C_LAT-1] = SRC_C;
    if (grantD_o) w_slot_nxt[D_LAT-1] = SRC_D;
  end

  // Reservation table register; recovery drops every in-flight reservation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= MAXL; k++) r_slot[k] <= SRC_NONE;
    end else if (recoverFlag_i) begin
      for (int k = 0; k <= MAXL; k++) r_slot[k] <= SRC_NONE;
    end else begin
      for (int k = 0; k <= MAXL; k++) r_slot[k] <= w_slot_nxt[k];
    end
  end

  // Divider occupancy FSM: busy for D_LAT-1 cycles after a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_state <= IDLE;
      r_div_cnt   <= 4'd0;
    end else if (recoverFlag_i) begin
      r_div_state <= IDLE;
      r_div_cnt   <= 4'd0;
    end else begin
      case (r_div_state)
        IDLE: begin
          if (grantD_o) begin
            r_div_state <= BUSY;
            r_div_cnt   <= 4'(D_LAT - 1);
          end
        end
        BUSY: begin
          r_div_cnt <= r_div_cnt - 4'd1;
          if (r_div_cnt == 4'd1) r_div_state <= IDLE;
        end
        default: begin
          r_div_state <= IDLE;
          r_div_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Consecutive simple-denial counter, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (recoverFlag_i) begin
      r_starve_cnt <= '0;
    end else if (reqS_i && !grantS_o) begin
      if (!w_starve) r_starve_cnt <= r_starve_cnt + SW'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_exe_wb_slot_scheduler.sv
// Bench for exe_wb_slot_scheduler: directed vector table, hand-written
// divider/starvation/reset sequences, and randomized traffic against a
// writeback-timeline reference model.
module tb_exe_wb_slot_scheduler;

  localparam int S_LAT      = 1;
  localparam int C_LAT      = 4;
  localparam int D_LAT      = 8;
  localparam int STARVE_MAX = 4;
  localparam int NRAND      = 1500;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       recoverFlag_i = 1'b0;
  logic       reqS_i = 1'b0;
  logic       reqC_i = 1'b0;
  logic       reqD_i = 1'b0;
  logic       grantS_o, grantC_o, grantD_o;
  logic [1:0] wbSel_o;
  logic       divBusy_o, starve_o;

  int checks = 0;
  int errors = 0;

  exe_wb_slot_scheduler #(
    .S_LAT(S_LAT), .C_LAT(C_LAT), .D_LAT(D_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .reqS_i(reqS_i), .reqC_i(reqC_i), .reqD_i(reqD_i),
    .grantS_o(grantS_o), .grantC_o(grantC_o), .grantD_o(grantD_o),
    .wbSel_o(wbSel_o), .divBusy_o(divBusy_o), .starve_o(starve_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit       rst;
    bit       s, c, d, r;
    bit       gs, gc, gd;
    bit [1:0] wb;
    bit       busy, st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit s, input bit c, input bit d, input bit r,
                     input bit gs, input bit gc, input bit gd, input int wb,
                     input bit busy, input bit st);
    vec_t v;
    v.rst = rst; v.s = s; v.c = c; v.d = d; v.r = r;
    v.gs = gs; v.gc = gc; v.gd = gd; v.wb = 2'(wb); v.busy = busy; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string nm, input bit gs, input bit gc, input bit gd,
                           input bit [1:0] wb, input bit busy, input bit st);
    chk({nm, ".grantS"},  {3'b0, grantS_o},  {3'b0, gs});
    chk({nm, ".grantC"},  {3'b0, grantC_o},  {3'b0, gc});
    chk({nm, ".grantD"},  {3'b0, grantD_o},  {3'b0, gd});
    chk({nm, ".wbSel"},   {2'b0, wbSel_o},   {2'b0, wb});
    chk({nm, ".divBusy"}, {3'b0, divBusy_o}, {3'b0, busy});
    chk({nm, ".starve"},  {3'b0, starve_o},  {3'b0, st});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; reqS_i = 0; reqC_i = 0; reqD_i = 0; recoverFlag_i = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one cycle's inputs away from the active edge and let combinational outputs settle.
  task automatic drive(input bit s, input bit c, input bit d, input bit r);
    @(negedge clk);
    reqS_i = s; reqC_i = c; reqD_i = d; recoverFlag_i = r;
    #1;
  endtask

  // Reference model: absolute writeback timeline, divider free time, denial streak.
  bit [1:0] m_resv [0:4095];
  int       m_t, m_div_free, m_scnt;

  task automatic m_reset();
    for (int k = 0; k < 4096; k++) m_resv[k] = 2'd0;
    m_t = 0; m_div_free = 0; m_scnt = 0;
  endtask

  task automatic m_step(input bit s, input bit c, input bit d, input bit r,
                        output bit gs, output bit gc, output bit gd,
                        output bit [1:0] wb, output bit busy, output bit st);
    bit es, ec, ed;
    wb   = m_resv[m_t];
    busy = (m_t < m_div_free);
    st   = (m_scnt == STARVE_MAX);
    es = s && (m_resv[m_t + S_LAT] == 0);
    ec = c && (m_resv[m_t + C_LAT] == 0);
    ed = d && (m_resv[m_t + D_LAT] == 0) && (m_t >= m_div_free);
    gs = 0; gc = 0; gd = 0;
    if (!r) begin
      if (st)      gs = es;
      else if (ed) gd = 1;
      else if (ec) gc = 1;
      else         gs = es;
    end
    if (gs) m_resv[m_t + S_LAT] = 2'd1;
    if (gc) m_resv[m_t + C_LAT] = 2'd2;
    if (gd) begin
      m_resv[m_t + D_LAT] = 2'd3;
      m_div_free = m_t + D_LAT;
    end
    if (r) begin
      for (int k = m_t + 1; k <= m_t + D_LAT + 1; k++) m_resv[k] = 2'd0;
      m_div_free = m_t + 1;
      m_scnt = 0;
    end else if (s && !gs) begin
      if (m_scnt < STARVE_MAX) m_scnt++;
    end else begin
      m_scnt = 0;
    end
    m_t++;
  endtask

  initial begin
    // Collision between complex and simple writebacks
    add(1, 1,1,0,0, 0,1,0, 0,0,0);
    add(0, 1,0,0,0, 1,0,0, 0,0,0);
    add(0, 1,0,0,0, 1,0,0, 1,0,0);
    add(0, 1,0,0,0, 0,0,0, 1,0,0);
    add(0, 1,0,0,0, 1,0,0, 2,0,0);
    add(0, 0,0,0,0, 0,0,0, 1,0,0);
    // Recovery flush
    add(1, 0,0,1,0, 0,0,1, 0,0,0);
    add(0, 0,1,0,0, 0,1,0, 0,1,0);
    add(0, 1,0,0,1, 0,0,0, 0,1,0);
    add(0, 0,0,1,0, 0,0,1, 0,0,0);
    for (int t = 4; t <= 12; t++)
      add(0, 0,0,0,0, 0,0,0, (t == 11) ? 3 : 0, (t >= 4 && t <= 10), 0);
    // Long-latency slot check
    add(1, 0,0,1,0, 0,0,1, 0,0,0);
    for (int t = 1; t <= 3; t++) add(0, 0,0,0,0, 0,0,0, 0,1,0);
    add(0, 0,1,0,0, 0,0,0, 0,1,0);
    add(0, 0,1,0,0, 0,1,0, 0,1,0);
    add(0, 0,0,0,0, 0,0,0, 0,1,0);
    add(0, 0,0,0,0, 0,0,0, 0,1,0);
    add(0, 0,0,0,0, 0,0,0, 3,0,0);
    add(0, 0,0,0,0, 0,0,0, 2,0,0);

    // Reset held with all requests high, then release into a D grant
    reset = 1'b0; reqS_i = 1; reqC_i = 1; reqD_i = 1;
    repeat (3) @(negedge clk);
    #1;
    check_out("reset_hold", 0,0,0, 0,0,0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_out("reset_release", 0,0,1, 0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].s, tbl[i].c, tbl[i].d, tbl[i].r);
      check_out($sformatf("vec%0d", i), tbl[i].gs, tbl[i].gc, tbl[i].gd,
                tbl[i].wb, tbl[i].busy, tbl[i].st);
    end

    // Divider held busy back-to-back
    do_reset();
    for (int t = 0; t <= 16; t++) begin
      drive(0, 0, 1, 0);
      check_out($sformatf("div_t%0d", t), 0, 0, (t % 8 == 0),
                (t == 8 || t == 16) ? 2'd3 : 2'd0, (t % 8 != 0), 0);
    end
    // Asynchronous reset while the divider is busy
    drive(0, 0, 0, 0);
    check_out("div_t17", 0,0,0, 0,1,0);
    #2 reset = 1'b0;
    #1;
    check_out("async_reset", 0,0,0, 0,0,0);

    // Starvation under continuous complex traffic
    do_reset();
    for (int t = 0; t <= 8; t++) begin
      drive(1, 1, 0, 0);
      check_out($sformatf("starve_t%0d", t), (t == 7), (t < 4) || (t == 8), 0,
                (t >= 4 && t <= 7) ? 2'd2 : ((t == 8) ? 2'd1 : 2'd0), 0,
                (t >= 4 && t <= 7));
    end

    // Randomized traffic against the timeline model
    do_reset();
    m_reset();
    for (int i = 0; i < NRAND; i++) begin
      bit s, c, d, r, gs, gc, gd, busy, st;
      bit [1:0] wb;
      s = ($urandom_range(0, 99) < 55);
      c = ($urandom_range(0, 99) < 65);
      d = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 3);
      drive(s, c, d, r);
      m_step(s, c, d, r, gs, gc, gd, wb, busy, st);
      check_out($sformatf("rnd%0d", i), gs, gc, gd, wb, busy, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
